// File: rtl/decode_stage.sv
// Registered RV32I-subset decode stage with valid/ready handshakes, load-use stall, flush and a saturating accept counter.
// Optional simulation trace of every accepted instruction when DECODE_TRACE_EN is defined.
module decode_stage #(
    parameter int IMM_W = 32,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REG_W-1:0] out_rs1,
    output logic [REG_W-1:0] out_rs2,
    output logic [REG_W-1:0] out_rd,
    output logic [IMM_W-1:0] out_imm,
    output logic [2:0]       out_alu_op,
    output logic             out_has_imm,
    output logic             out_rf_we,
    output logic             out_mem_we,
    output logic             out_mem_re,
    output logic             out_branch,
    output logic             out_branch_ne,
    output logic             out_illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [REG_W-1:0] dec_rs1, dec_rs2, dec_rd;
    logic [IMM_W-1:0] imm_i, imm_s, imm_b, dec_imm;
    logic [2:0]       dec_alu_op, alu_code;
    logic             alu_legal;
    logic             dec_has_imm, dec_rf_we, dec_mem_we, dec_mem_re;
    logic             dec_branch, dec_branch_ne, dec_illegal;
    logic             uses_rs1, uses_rs2, hazard, accept;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign dec_rd  = REG_W'(in_instr[11:7]);
    assign dec_rs1 = REG_W'(in_instr[19:15]);
    assign dec_rs2 = REG_W'(in_instr[24:20]);

    assign imm_i = {{(IMM_W-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(IMM_W-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(IMM_W-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};

    // funct3 doubles as the ALU code except ADD (000), which maps to 001
    assign alu_legal = (funct3 == 3'b000) || (funct3 == 3'b100) ||
                       (funct3 == 3'b110) || (funct3 == 3'b111);
    assign alu_code  = (funct3 == 3'b000) ? 3'b001 : funct3;

    always_comb begin
        dec_imm       = '0;
        dec_alu_op    = 3'b000;
        dec_has_imm   = 1'b0;
        dec_rf_we     = 1'b0;
        dec_mem_we    = 1'b0;
        dec_mem_re    = 1'b0;
        dec_branch    = 1'b0;
        dec_branch_ne = 1'b0;
        dec_illegal   = 1'b1;
        case (opcode)
            OPC_OPIMM: if (alu_legal) begin
                dec_illegal = 1'b0;
                dec_alu_op  = alu_code;
                dec_imm     = imm_i;
                dec_has_imm = 1'b1;
                dec_rf_we   = 1'b1;
            end
            OPC_OP: if (alu_legal && funct7 == 7'd0) begin
                dec_illegal = 1'b0;
                dec_alu_op  = alu_code;
                dec_rf_we   = 1'b1;
            end
            OPC_LOAD: if (funct3 == 3'b010) begin
                dec_illegal = 1'b0;
                dec_alu_op  = 3'b001;
                dec_imm     = imm_i;
                dec_has_imm = 1'b1;
                dec_mem_re  = 1'b1;
                dec_rf_we   = 1'b1;
            end
            OPC_STORE: if (funct3 == 3'b010) begin
                dec_illegal = 1'b0;
                dec_alu_op  = 3'b001;
                dec_imm     = imm_s;
                dec_has_imm = 1'b1;
                dec_mem_we  = 1'b1;
            end
            OPC_BRANCH: if (funct3[2:1] == 2'b00) begin
                dec_illegal   = 1'b0;
                dec_alu_op    = 3'b100;
                dec_imm       = imm_b;
                dec_branch    = 1'b1;
                dec_branch_ne = funct3[0];
            end
            default: ;
        endcase
    end

    // Operand usage follows the instruction format, independent of funct legality
    assign uses_rs1 = (opcode == OPC_OPIMM) || (opcode == OPC_OP) || (opcode == OPC_LOAD) ||
                      (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign hazard   = out_valid && out_mem_re && (out_rd != '0) &&
                      ((uses_rs1 && dec_rs1 == out_rd) || (uses_rs2 && dec_rs2 == out_rd));
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_imm       <= '0;
            out_alu_op    <= 3'b000;
            out_has_imm   <= 1'b0;
            out_rf_we     <= 1'b0;
            out_mem_we    <= 1'b0;
            out_mem_re    <= 1'b0;
            out_branch    <= 1'b0;
            out_branch_ne <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_rs1       <= dec_rs1;
            out_rs2       <= dec_rs2;
            out_rd        <= dec_rd;
            out_imm       <= dec_imm;
            out_alu_op    <= dec_alu_op;
            out_has_imm   <= dec_has_imm;
            out_rf_we     <= dec_rf_we;
            out_mem_we    <= dec_mem_we;
            out_mem_re    <= dec_mem_re;
            out_branch    <= dec_branch;
            out_branch_ne <= dec_branch_ne;
            out_illegal   <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_cnt <= '0;
        else if (accept && instr_cnt != '1)
            instr_cnt <= instr_cnt + 1'b1;
    end

`ifdef DECODE_TRACE_EN
    function automatic string mnemonic(input logic [6:0] opc, input logic [2:0] f3, input logic ill);
        string s;
        s = "ILLEGAL";
        if (!ill) begin
            case (opc)
                OPC_OPIMM:  s = (f3 == 3'b000) ? "ADDI" : (f3 == 3'b100) ? "XORI" :
                                (f3 == 3'b110) ? "ORI"  : "ANDI";
                OPC_OP:     s = (f3 == 3'b000) ? "ADD"  : (f3 == 3'b100) ? "XOR"  :
                                (f3 == 3'b110) ? "OR"   : "AND";
                OPC_LOAD:   s = "LW";
                OPC_STORE:  s = "SW";
                OPC_BRANCH: s = f3[0] ? "BNE" : "BEQ";
                default:    s = "ILLEGAL";
            endcase
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst_n && accept)
            $display("%0t %s rd=%h rs1=%h rs2=%h imm=%h", $time,
                     mnemonic(opcode, funct3, dec_illegal), dec_rd, dec_rs1, dec_rs2, dec_imm);
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage with a cycle model of the handshake and a scoreboard queue of expected decodes.
module tb_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [2:0]  op;
        logic        has_imm, rf_we, mem_we, mem_re, br, bne, ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [31:0] in_instr;
    logic        in_ready, out_valid;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm;
    logic [2:0]  out_alu_op;
    logic        out_has_imm, out_rf_we, out_mem_we, out_mem_re, out_branch, out_branch_ne, out_illegal;
    logic [15:0] instr_cnt;

    logic        in_ready2, out_valid2;
    logic [4:0]  out_rs1_2, out_rs2_2, out_rd_2;
    logic [31:0] out_imm_2;
    logic [2:0]  out_alu_op_2;
    logic        out_has_imm_2, out_rf_we_2, out_mem_we_2, out_mem_re_2;
    logic        out_branch_2, out_branch_ne_2, out_illegal_2;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_has_imm(out_has_imm), .out_rf_we(out_rf_we),
        .out_mem_we(out_mem_we), .out_mem_re(out_mem_re), .out_branch(out_branch),
        .out_branch_ne(out_branch_ne), .out_illegal(out_illegal), .instr_cnt(instr_cnt)
    );

    decode_stage #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_instr(in_instr),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .out_rs1(out_rs1_2), .out_rs2(out_rs2_2), .out_rd(out_rd_2), .out_imm(out_imm_2),
        .out_alu_op(out_alu_op_2), .out_has_imm(out_has_imm_2), .out_rf_we(out_rf_we_2),
        .out_mem_we(out_mem_we_2), .out_mem_re(out_mem_re_2), .out_branch(out_branch_2),
        .out_branch_ne(out_branch_ne_2), .out_illegal(out_illegal_2), .instr_cnt(cnt2)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic mvalid;
    vec_t mcur;
    int   mcnt, mcnt2;
    vec_t exp_q[$];

    function automatic vec_t mk(input logic [31:0] i, input int rd, input int rs1, input int rs2,
                                input logic [31:0] imm, input logic [2:0] op, input logic [6:0] fl);
        vec_t v;
        v.instr = i; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.imm = imm; v.op = op;
        {v.has_imm, v.rf_we, v.mem_we, v.mem_re, v.br, v.bne, v.ill} = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic model_hazard(input logic [31:0] ins);
        logic [6:0] opc;
        logic u1, u2;
        opc = ins[6:0];
        u1 = (opc == 7'b0010011) || (opc == 7'b0110011) || (opc == 7'b0000011) ||
             (opc == 7'b0100011) || (opc == 7'b1100011);
        u2 = (opc == 7'b0110011) || (opc == 7'b0100011) || (opc == 7'b1100011);
        return mvalid && mcur.mem_re && (mcur.rd != 5'd0) &&
               ((u1 && ins[19:15] == mcur.rd) || (u2 && ins[24:20] == mcur.rd));
    endfunction

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(mvalid));
        chk("instr_cnt", 32'(instr_cnt), 32'(mcnt));
        chk("instr_cnt_w2", 32'(cnt2), 32'(mcnt2));
        if (mvalid) begin
            chk("rd", 32'(out_rd), 32'(mcur.rd));
            chk("rs1", 32'(out_rs1), 32'(mcur.rs1));
            chk("rs2", 32'(out_rs2), 32'(mcur.rs2));
            chk("imm", out_imm, mcur.imm);
            chk("alu_op", 32'(out_alu_op), 32'(mcur.op));
            chk("has_imm", 32'(out_has_imm), 32'(mcur.has_imm));
            chk("rf_we", 32'(out_rf_we), 32'(mcur.rf_we));
            chk("mem_we", 32'(out_mem_we), 32'(mcur.mem_we));
            chk("mem_re", 32'(out_mem_re), 32'(mcur.mem_re));
            chk("branch", 32'(out_branch), 32'(mcur.br));
            if (mcur.br) chk("branch_ne", 32'(out_branch_ne), 32'(mcur.bne));
            chk("illegal", 32'(out_illegal), 32'(mcur.ill));
        end
    endtask

    // Drive one cycle from posedge+1, check in_ready, then check the registered outputs at the next posedge+1
    task automatic cycle(input logic v, input vec_t x, input logic ordy, input logic fl, output logic acc);
        logic exp_rdy;
        in_valid = v; in_instr = x.instr; out_ready = ordy; flush = fl;
        #1;
        exp_rdy = !fl && !model_hazard(x.instr) && (!mvalid || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        if (acc) exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (fl) begin
            mvalid = 1'b0;
        end else if (acc) begin
            mcur = exp_q.pop_front();
            mvalid = 1'b1;
            if (mcnt < 65535) mcnt++;
            if (mcnt2 < 3) mcnt2++;
            $display("txn instr=%08h rd=%0d rs1=%0d rs2=%0d imm=%08h cnt=%0d",
                     mcur.instr, out_rd, out_rs1, out_rs2, out_imm, instr_cnt);
        end else if (ordy) begin
            mvalid = 1'b0;
        end
        check_out();
    endtask

    task automatic send(input vec_t x);
        logic acc;
        for (int t = 0; t < 8; t++) begin
            cycle(1'b1, x, 1'b1, 1'b0, acc);
            if (acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: instr %08h got no accept, required accept within 8 cycles", x.instr);
    endtask

    vec_t tbl[13];
    vec_t v_sw, v_xori, v_andi, v_all1, v_lw, v_add, v_addi, v_nop;
    logic acc;

    initial begin
        tbl[0]  = mk(32'h00500093, 1, 0, 5,  32'h00000005, 3'b001, 7'b1100000); // ADDI x1,x0,5
        tbl[1]  = mk(32'h0000A283, 5, 1, 0,  32'h00000000, 3'b001, 7'b1101000); // LW x5,0(x1)
        tbl[2]  = mk(32'h00028333, 6, 5, 0,  32'h00000000, 3'b001, 7'b0100000); // ADD x6,x5,x0 (rs1 hazard)
        tbl[3]  = mk(32'hFFF0C193, 3, 1, 31, 32'hFFFFFFFF, 3'b100, 7'b1100000); // XORI x3,x1,-1
        tbl[4]  = mk(32'h7FF16213, 4, 2, 31, 32'h000007FF, 3'b110, 7'b1100000); // ORI x4,x2,0x7ff
        tbl[5]  = mk(32'h8001F393, 7, 3, 0,  32'hFFFFF800, 3'b111, 7'b1100000); // ANDI x7,x3,-2048
        tbl[6]  = mk(32'h0000A503, 10, 1, 0, 32'h00000000, 3'b001, 7'b1101000); // LW x10,0(x1)
        tbl[7]  = mk(32'h00A4C433, 8, 9, 10, 32'h00000000, 3'b100, 7'b0100000); // XOR x8,x9,x10 (rs2 hazard)
        tbl[8]  = mk(32'h40A4E433, 8, 9, 10, 32'h00000000, 3'b000, 7'b0000001); // OR with funct7!=0
        tbl[9]  = mk(32'h0020F033, 0, 1, 2,  32'h00000000, 3'b111, 7'b0100000); // AND x0,x1,x2
        tbl[10] = mk(32'h00318463, 8, 3, 3,  32'h00000008, 3'b100, 7'b0000100); // BEQ x3,x3,+8
        tbl[11] = mk(32'hFE209EE3, 29, 1, 2, 32'hFFFFFFFC, 3'b100, 7'b0000110); // BNE x1,x2,-4
        tbl[12] = mk(32'h00008283, 5, 1, 0,  32'h00000000, 3'b000, 7'b0000001); // LB (unsupported)
        v_sw   = mk(32'h0020A423, 8, 1, 2,   32'h00000008, 3'b001, 7'b1010000);
        v_xori = tbl[3];
        v_andi = tbl[5];
        v_lw   = tbl[1];
        v_add  = tbl[2];
        v_addi = tbl[0];
        v_all1 = mk(32'hFFFFFFFF, 31, 31, 31, 32'h00000000, 3'b000, 7'b0000001);
        v_nop  = mk(32'h00000000, 0, 0, 0, 32'h00000000, 3'b000, 7'b0000000);

        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; flush = 1'b0; out_ready = 1'b0;
        mvalid = 1'b0; mcnt = 0; mcnt2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_instr_cnt", 32'(instr_cnt), 32'd0);
        chk("reset_imm", out_imm, 32'd0);
        chk("reset_rf_we", 32'(out_rf_we), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        foreach (tbl[i]) send(tbl[i]);
        cycle(1'b0, v_nop, 1'b1, 1'b0, acc);

        // store held under back-pressure, next instruction taken when out_ready rises
        cycle(1'b1, v_sw, 1'b0, 1'b0, acc);
        repeat (3) cycle(1'b1, v_xori, 1'b0, 1'b0, acc);
        cycle(1'b1, v_xori, 1'b1, 1'b0, acc);

        // flush with a held instruction and a pending one, then an all-ones word
        cycle(1'b1, v_andi, 1'b0, 1'b1, acc);
        cycle(1'b1, v_all1, 1'b1, 1'b0, acc);

        // load-use hazard persisting under back-pressure
        cycle(1'b1, v_lw, 1'b1, 1'b0, acc);
        repeat (2) cycle(1'b1, v_add, 1'b0, 1'b0, acc);
        send(v_add);

        // asynchronous reset in the middle of a held transfer
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_instr_cnt", 32'(instr_cnt), 32'd0);
        chk("midreset_cnt_w2", 32'(cnt2), 32'd0);
        chk("midreset_rd", 32'(out_rd), 32'd0);
        mvalid = 1'b0; mcnt = 0; mcnt2 = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(v_addi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
